// File: rtl/cheby_bf16.sv
// cheby_bf16: BF16 exp(x) unit. One operand is in flight at a time.
// The operand is converted to Q8.16 fixed point and range-reduced to 2^n * 2^f.
// 2^f is evaluated as a cubic Horner polynomial on one shared multiplier,
// and the result is repacked as BF16.
// The special-case inputs (NaN, Inf, zero/denormal, out-of-range) are resolved
// in the reduce step and carried to the output through the same state sequence,
// so they see the same latency as ordinary operands.
module cheby_bf16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REDUCE = 3'd1;
  localparam logic [2:0] S_POLY1  = 3'd2;
  localparam logic [2:0] S_POLY2  = 3'd3;
  localparam logic [2:0] S_POLY3  = 3'd4;
  localparam logic [2:0] S_PACK   = 3'd5;
  localparam logic [2:0] S_OUT    = 3'd6;

  // log2(e) in Q1.16, and the Horner coefficients of 2^f in Q.16
  localparam logic [16:0] LOG2E = 17'd94548;
  localparam logic [17:0] C0    = 18'd65536;
  localparam logic [17:0] C1    = 18'd45600;
  localparam logic [17:0] C2    = 18'd14752;
  localparam logic [17:0] C3    = 18'd5184;

  localparam logic [15:0] BF_NAN  = 16'h7FC0;
  localparam logic [15:0] BF_PINF = 16'h7F80;
  localparam logic [15:0] BF_ZERO = 16'h0000;
  localparam logic [15:0] BF_ONE  = 16'h3F80;

  logic [2:0]         state_q, state_d;
  logic [15:0]        x_q, x_d;
  logic               special_q, special_d;
  logic [15:0]        spec_res_q, spec_res_d;
  logic signed [10:0] n_q, n_d;
  logic [15:0]        f_q, f_d;
  logic [17:0]        acc_q, acc_d;
  logic [15:0]        out_data_q, out_data_d;

  logic               red_sign;
  logic [7:0]         red_exp;
  logic [6:0]         red_man;
  logic [7:0]         red_sig;
  logic [23:0]        red_mag;
  logic signed [24:0] red_fx;
  logic signed [42:0] red_prod;
  logic signed [26:0] red_t;
  logic               red_special;
  logic [15:0]        red_spec_res;

  logic [33:0]        mul_full;
  logic [17:0]        mul_q16;
  logic [17:0]        poly_coeff;

  logic [17:0]        pk_p;
  logic signed [10:0] pk_n;
  logic [7:0]         pk_m8;
  logic [6:0]         pk_m;
  logic signed [10:0] pk_e;
  logic [15:0]        pk_res;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;

  // Range reduction: BF16 -> signed Q8.16 X (truncated), then T = X*log2(e),
  // which is split into integer exponent n (floor) and fraction f.
  // The special operands are also classified here.
  always_comb begin
    red_sign     = x_q[15];
    red_exp      = x_q[14:7];
    red_man      = x_q[6:0];
    red_sig      = {1'b1, red_man};
    red_mag      = 24'd0;
    if (red_exp >= 8'd118) begin
      red_mag = {16'd0, red_sig} << (red_exp - 8'd118);
    end else if (red_exp >= 8'd111) begin
      red_mag = {16'd0, red_sig} >> (8'd118 - red_exp);
    end
    red_fx       = red_sign ? -$signed({1'b0, red_mag}) : $signed({1'b0, red_mag});
    red_prod     = 43'(red_fx) * $signed({26'd0, LOG2E});
    red_t        = 27'(red_prod >>> 16);

    red_special  = 1'b1;
    red_spec_res = BF_ZERO;
    if (red_exp == 8'hFF) begin
      if (red_man != 7'd0) begin
        red_spec_res = BF_NAN;
      end else begin
        red_spec_res = red_sign ? BF_ZERO : BF_PINF;
      end
    end else if (red_exp == 8'h00) begin
      red_spec_res = BF_ONE;
    end else if (red_exp >= 8'd134) begin
      red_spec_res = red_sign ? BF_ZERO : BF_PINF;
    end else begin
      red_special = 1'b0;
    end
  end

  // Shared Horner step: acc <- coeff + (f * acc) >> 16, coefficient picked by state
  always_comb begin
    mul_full   = 34'(f_q) * 34'(acc_q);
    mul_q16    = 18'(mul_full >> 16);
    poly_coeff = C0;
    case (state_q)
      S_POLY1: poly_coeff = C2;
      S_POLY2: poly_coeff = C1;
      default: poly_coeff = C0;
    endcase
  end

  // Normalization, mantissa rounding on P[8] and BF16 packing with saturation
  always_comb begin
    pk_p = acc_q;
    pk_n = n_q;
    if (pk_p >= 18'd131072) begin
      pk_p = pk_p >> 1;
      pk_n = pk_n + 11'sd1;
    end
    pk_m8 = {1'b0, pk_p[15:9]} + {7'd0, pk_p[8]};
    if (pk_m8[7]) begin
      pk_m = 7'd0;
      pk_n = pk_n + 11'sd1;
    end else begin
      pk_m = pk_m8[6:0];
    end
    pk_e = pk_n + 11'sd127;
    if (special_q) begin
      pk_res = spec_res_q;
    end else if (pk_e >= 11'sd255) begin
      pk_res = BF_PINF;
    end else if (pk_e <= 11'sd0) begin
      pk_res = BF_ZERO;
    end else begin
      pk_res = {1'b0, pk_e[7:0], pk_m};
    end
  end

  // Sequencing of the operation and the next value of every datapath register
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    n_d        = n_q;
    f_d        = f_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        special_d  = red_special;
        spec_res_d = red_spec_res;
        n_d        = red_t[26:16];
        f_d        = red_t[15:0];
        acc_d      = C3;
        state_d    = S_POLY1;
      end
      S_POLY1: begin
        acc_d   = poly_coeff + mul_q16;
        state_d = S_POLY2;
      end
      S_POLY2: begin
        acc_d   = poly_coeff + mul_q16;
        state_d = S_POLY3;
      end
      S_POLY3: begin
        acc_d   = poly_coeff + mul_q16;
        state_d = S_PACK;
      end
      S_PACK: begin
        out_data_d = pk_res;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset drops any operation in flight and clears the datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      x_q        <= 16'd0;
      special_q  <= 1'b0;
      spec_res_q <= 16'd0;
      n_q        <= 11'sd0;
      f_q        <= 16'd0;
      acc_q      <= 18'd0;
      out_data_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      n_q        <= n_d;
      f_q        <= f_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_cheby_bf16.sv
// tb_cheby_bf16: directed and randomized checks of cheby_bf16 against a
// plain-arithmetic model of the BF16 exp algorithm.
module tb_cheby_bf16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  cheby_bf16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  // free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference exp(x) from the arithmetic rules, using wide integers
  function automatic logic [15:0] ref_exp(input logic [15:0] x);
    longint sgn, e, man, mag, xf, t, n, f, a, b, p, m, eb;
    sgn = longint'(x[15]);
    e   = longint'(x[14:7]);
    man = longint'(x[6:0]);
    if (e == 255) begin
      if (man != 0) return 16'h7FC0;
      return (sgn != 0) ? 16'h0000 : 16'h7F80;
    end
    if (e == 0) return 16'h3F80;
    if (e - 127 >= 7) return (sgn != 0) ? 16'h0000 : 16'h7F80;
    // value = (128+man) * 2^(e-127-7); scaled by 2^16
    if (e >= 118) mag = (128 + man) * (longint'(1) << (e - 118));
    else if (e >= 111) mag = (128 + man) / (longint'(1) << (118 - e));
    else mag = 0;
    xf = (sgn != 0) ? -mag : mag;
    t  = (xf * 94548) >>> 16;
    n  = t >>> 16;
    f  = t - n * 65536;
    a  = 14752 + ((f * 5184) >> 16);
    b  = 45600 + ((f * a) >> 16);
    p  = 65536 + ((f * b) >> 16);
    if (p >= 131072) begin
      n = n + 1;
      p = p >> 1;
    end
    m = ((p >> 9) & 127) + ((p >> 8) & 1);
    if (m == 128) begin
      m = 0;
      n = n + 1;
    end
    eb = n + 127;
    if (eb >= 255) return 16'h7F80;
    if (eb <= 0) return 16'h0000;
    return {1'b0, eb[7:0], m[6:0]};
  endfunction

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Feeds one operand, checks latency and result, holds out_ready low for
  // stall cycles (checking the result is held) and then consumes it
  task automatic applyStimulus(input logic [15:0] x, input int stall, input string tag);
    logic [15:0] exp_v;
    int          edges;
    exp_v = ref_exp(x);
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'h0000;
    edges    = 1;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    // out_valid rises on the sixth edge, counting the accepting edge as the first
    checkOutput({tag, "_latency"}, 16'(edges), 16'd6);
    checkOutput({tag, "_data"}, out_data, exp_v);
    if (stall > 0) begin
      in_valid = 1'b1;
      in_data  = ~x;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        checkOutput({tag, "_hold_valid"}, {15'd0, out_valid}, 16'd1);
        checkOutput({tag, "_hold_data"}, out_data, exp_v);
        checkOutput({tag, "_hold_ready"}, {15'd0, in_ready}, 16'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    // consume edge returns to IDLE; an in_valid held high must not have been taken
    checkOutput({tag, "_post_valid"}, {15'd0, out_valid}, 16'd0);
    checkOutput({tag, "_post_ready"}, {15'd0, in_ready}, 16'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Directed scenarios followed by randomized operands
  initial begin
    logic [15:0] x;
    int          seen;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("rst_out_data", out_data, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rel_in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("rel_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("rel_out_data", out_data, 16'h0000);

    applyStimulus(16'h3F80, 0, "one");
    checkOutput("one_abs", out_data, 16'h402E);
    applyStimulus(16'hBF80, 0, "mone");
    checkOutput("mone_abs", out_data, 16'h3EBC);
    applyStimulus(16'h0000, 0, "pzero");
    checkOutput("pzero_abs", out_data, 16'h3F80);
    applyStimulus(16'h8000, 0, "nzero");
    checkOutput("nzero_abs", out_data, 16'h3F80);
    applyStimulus(16'h42C8, 0, "p100");
    checkOutput("p100_abs", out_data, 16'h7F80);
    applyStimulus(16'hC2C8, 0, "m100");
    checkOutput("m100_abs", out_data, 16'h0000);
    applyStimulus(16'h7FC1, 0, "nan");
    checkOutput("nan_abs", out_data, 16'h7FC0);
    applyStimulus(16'hFF80, 0, "minf");
    checkOutput("minf_abs", out_data, 16'h0000);
    applyStimulus(16'h7F80, 0, "pinf");
    applyStimulus(16'h0001, 0, "denorm");
    applyStimulus(16'h4300, 0, "clamp128");
    applyStimulus(16'h3F80, 10, "stall");

    // reset pulsed while the operation is in POLY2
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h3F80;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("midrst_out_data", out_data, 16'h0000);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("midrst_no_result", 16'(seen), 16'd0);
    out_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      x[15]   = 1'($urandom_range(0, 1));
      x[14:7] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 1) * 255)
                                           : 8'($urandom_range(105, 136));
      x[6:0]  = 7'($urandom_range(0, 127));
      applyStimulus(x, int'($urandom_range(0, 3)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
